// File: rtl/bti_router.sv
`default_nettype none
// ============================================================================
// Module   : bti_router
// Purpose  : Routes host BTI requests to one of GST_NUM guests by address MSB
//            selector and returns responses strictly in request order.
// Revision : 1.0 - initial release
// ============================================================================
module bti_router #(
    parameter int                            BTI_AW      = 32,
    parameter int                            BTI_DW      = 32,
    parameter int                            GST_SEL_AW  = 8,
    parameter int                            GST_NUM     = 4,
    parameter logic [GST_NUM*GST_SEL_AW-1:0] GST_SEL     = {8'h30, 8'h20, 8'h10, 8'h00},
    parameter logic [GST_NUM*32-1:0]         GST_AW      = {4{32'd24}},
    parameter int                            OST_DEPTH   = 4,
    parameter logic [BTI_DW-1:0]             DECERR_DATA = 32'hDEAD_BEEF
) (
    input  logic                           clk,
    input  logic                           rst_n,
    // host request
    input  logic                           host_req_vld,
    output logic                           host_req_rdy,
    input  logic [BTI_AW-1:0]              host_req_addr,
    input  logic                           host_req_wr,
    input  logic [BTI_DW-1:0]              host_req_wdata,
    input  logic [BTI_DW/8-1:0]            host_req_wmask,
    // host response
    output logic                           host_rsp_vld,
    input  logic                           host_rsp_rdy,
    output logic [BTI_DW-1:0]              host_rsp_rdata,
    output logic                           host_rsp_ok,
    // guest requests
    output logic [GST_NUM-1:0]             gst_req_vld,
    input  logic [GST_NUM-1:0]             gst_req_rdy,
    output logic [GST_NUM*BTI_AW-1:0]      gst_req_addr,
    output logic [GST_NUM-1:0]             gst_req_wr,
    output logic [GST_NUM*BTI_DW-1:0]      gst_req_wdata,
    output logic [GST_NUM*(BTI_DW/8)-1:0]  gst_req_wmask,
    // guest responses
    input  logic [GST_NUM-1:0]             gst_rsp_vld,
    output logic [GST_NUM-1:0]             gst_rsp_rdy,
    input  logic [GST_NUM*BTI_DW-1:0]      gst_rsp_rdata,
    input  logic [GST_NUM-1:0]             gst_rsp_ok,
    // status
    output logic [$clog2(OST_DEPTH):0]     ost_cnt,
    output logic                           err_stray
);

    localparam int c_MW  = BTI_DW / 8;
    localparam int c_IDW = $clog2(GST_NUM + 1);
    localparam int c_PW  = $clog2(OST_DEPTH);
    localparam int c_CW  = c_PW + 1;
    // Order-FIFO entry value meaning "no guest, answer with a decode error"
    localparam logic [c_IDW-1:0] c_DECERR_ID = c_IDW'(GST_NUM);

    logic [GST_SEL_AW-1:0] w_sel;
    logic                  w_hit_any;
    logic                  w_hit_rdy;
    logic [c_IDW-1:0]      w_hit_idx;

    logic [c_IDW-1:0]      r_fifo [OST_DEPTH];
    logic [c_PW-1:0]       r_wptr;
    logic [c_PW-1:0]       r_rptr;
    logic [c_CW-1:0]       r_cnt;
    logic                  r_err_stray;

    logic                  w_full;
    logic                  w_empty;
    logic                  w_push;
    logic                  w_pop;
    logic [c_IDW-1:0]      w_push_id;
    logic [c_IDW-1:0]      w_head;
    logic [GST_NUM-1:0]    w_head_oh;

    assign w_sel = host_req_addr[BTI_AW-1 -: GST_SEL_AW];

    // Descending scan so the lowest matching guest overwrites the others
    always_comb begin
        w_hit_any = 1'b0;
        w_hit_rdy = 1'b0;
        w_hit_idx = '0;
        for (int i = GST_NUM - 1; i >= 0; i--) begin
            if (w_sel == GST_SEL[i*GST_SEL_AW +: GST_SEL_AW]) begin
                w_hit_any = 1'b1;
                w_hit_rdy = gst_req_rdy[i];
                w_hit_idx = c_IDW'(i);
            end
        end
    end

    assign w_full       = (r_cnt == c_CW'(OST_DEPTH));
    assign w_empty      = (r_cnt == '0);
    assign host_req_rdy = ~w_full & (w_hit_any ? w_hit_rdy : 1'b1);
    assign w_push       = host_req_vld & host_req_rdy;
    assign w_push_id    = w_hit_any ? w_hit_idx : c_DECERR_ID;

    for (genvar g = 0; g < GST_NUM; g++) begin : g_guest
        localparam int c_GAW = GST_AW[g*32 +: 32];
        logic [BTI_AW-1:0] w_addr_mask;

        for (genvar b = 0; b < BTI_AW; b++) begin : g_mask_bit
            assign w_addr_mask[b] = (b < c_GAW);
        end

        assign gst_req_vld[g]                    = rst_n & host_req_vld & ~w_full & w_hit_any
                                                   & (w_hit_idx == c_IDW'(g));
        assign gst_req_addr[g*BTI_AW +: BTI_AW]  = host_req_addr & w_addr_mask;
        assign gst_req_wr[g]                     = host_req_wr;
        assign gst_req_wdata[g*BTI_DW +: BTI_DW] = host_req_wdata;
        assign gst_req_wmask[g*c_MW +: c_MW]     = host_req_wmask;
    end

    assign w_head = r_fifo[r_rptr];

    always_comb begin
        host_rsp_vld   = 1'b0;
        host_rsp_rdata = '0;
        host_rsp_ok    = 1'b0;
        gst_rsp_rdy    = '0;
        w_head_oh      = '0;
        if (!w_empty) begin
            if (w_head == c_DECERR_ID) begin
                host_rsp_vld   = 1'b1;
                host_rsp_rdata = DECERR_DATA;
            end else begin
                for (int i = 0; i < GST_NUM; i++) begin
                    if (w_head == c_IDW'(i)) begin
                        w_head_oh[i]   = 1'b1;
                        host_rsp_vld   = gst_rsp_vld[i];
                        host_rsp_rdata = gst_rsp_rdata[i*BTI_DW +: BTI_DW];
                        host_rsp_ok    = gst_rsp_ok[i];
                        gst_rsp_rdy[i] = host_rsp_rdy;
                    end
                end
            end
        end
    end

    assign w_pop = host_rsp_vld & host_rsp_rdy;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wptr      <= '0;
            r_rptr      <= '0;
            r_cnt       <= '0;
            r_err_stray <= 1'b0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + c_PW'(1);
            end
            if (w_pop) begin
                r_rptr <= r_rptr + c_PW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_cnt <= r_cnt + c_CW'(1);
                2'b01:   r_cnt <= r_cnt - c_CW'(1);
                default: r_cnt <= r_cnt;
            endcase
            // Any guest offering a response that is not the current head is stray
            r_err_stray <= |(gst_rsp_vld & ~w_head_oh);
        end
    end

    // Entry storage needs no reset: only slots between the pointers are read
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_fifo[r_wptr] <= w_push_id;
        end
    end

    assign ost_cnt   = r_cnt;
    assign err_stray = r_err_stray;

endmodule
`default_nettype wire

// File: tb/tb_bti_router.sv
`default_nettype none
// ============================================================================
// Module   : tb_bti_router
// Purpose  : Directed and randomized self-checking bench for bti_router.
// Revision : 1.0 - initial release
// ============================================================================
module tb_bti_router;

    localparam int NG = 4;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int MW = 4;

    // Guest map: guest 3 shares selector 0x10 with guest 1 and must never win
    localparam logic [NG*8-1:0]  c_SEL = {8'h10, 8'h20, 8'h10, 8'h00};
    localparam logic [NG*32-1:0] c_GAW = {32'd12, 32'd20, 32'd17, 32'd24};

    logic [7:0] sel_tab [NG] = '{8'h00, 8'h10, 8'h20, 8'h10};
    int         aw_tab  [NG] = '{24, 17, 20, 12};
    logic [7:0] tops    [6]  = '{8'h00, 8'h10, 8'h20, 8'h30, 8'h50, 8'hFF};

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic              host_req_vld   = 1'b0;
    logic              host_req_rdy;
    logic [AW-1:0]     host_req_addr  = '0;
    logic              host_req_wr    = 1'b0;
    logic [DW-1:0]     host_req_wdata = '0;
    logic [MW-1:0]     host_req_wmask = '0;
    logic              host_rsp_vld;
    logic              host_rsp_rdy;
    logic [DW-1:0]     host_rsp_rdata;
    logic              host_rsp_ok;
    logic [NG-1:0]     gst_req_vld;
    logic [NG-1:0]     gst_req_rdy;
    logic [NG*AW-1:0]  gst_req_addr;
    logic [NG-1:0]     gst_req_wr;
    logic [NG*DW-1:0]  gst_req_wdata;
    logic [NG*MW-1:0]  gst_req_wmask;
    logic [NG-1:0]     gst_rsp_vld;
    logic [NG-1:0]     gst_rsp_rdy;
    logic [NG*DW-1:0]  gst_rsp_rdata;
    logic [NG-1:0]     gst_rsp_ok;
    logic [2:0]        ost_cnt;
    logic              err_stray;

    // Directed-phase drive values and random-environment drive values
    logic              env_en           = 1'b0;
    logic [NG-1:0]     man_req_rdy      = '0;
    logic [NG-1:0]     man_rsp_vld      = '0;
    logic [NG*DW-1:0]  man_rsp_rdata    = '0;
    logic [NG-1:0]     man_rsp_ok       = '0;
    logic              man_host_rsp_rdy = 1'b0;
    logic [NG-1:0]     env_req_rdy      = '0;
    logic [NG-1:0]     env_rsp_vld      = '0;
    logic [NG*DW-1:0]  env_rsp_rdata    = '0;
    logic [NG-1:0]     env_rsp_ok       = '0;
    logic              env_host_rsp_rdy = 1'b0;
    logic [NG-1:0]     env_acc          = '0;

    assign gst_req_rdy   = env_en ? env_req_rdy      : man_req_rdy;
    assign gst_rsp_vld   = env_en ? env_rsp_vld      : man_rsp_vld;
    assign gst_rsp_rdata = env_en ? env_rsp_rdata    : man_rsp_rdata;
    assign gst_rsp_ok    = env_en ? env_rsp_ok       : man_rsp_ok;
    assign host_rsp_rdy  = env_en ? env_host_rsp_rdy : man_host_rsp_rdy;

    bti_router #(
        .BTI_AW      (AW),
        .BTI_DW      (DW),
        .GST_SEL_AW  (8),
        .GST_NUM     (NG),
        .GST_SEL     (c_SEL),
        .GST_AW      (c_GAW),
        .OST_DEPTH   (4),
        .DECERR_DATA (32'hDEAD_BEEF)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .host_req_vld   (host_req_vld),
        .host_req_rdy   (host_req_rdy),
        .host_req_addr  (host_req_addr),
        .host_req_wr    (host_req_wr),
        .host_req_wdata (host_req_wdata),
        .host_req_wmask (host_req_wmask),
        .host_rsp_vld   (host_rsp_vld),
        .host_rsp_rdy   (host_rsp_rdy),
        .host_rsp_rdata (host_rsp_rdata),
        .host_rsp_ok    (host_rsp_ok),
        .gst_req_vld    (gst_req_vld),
        .gst_req_rdy    (gst_req_rdy),
        .gst_req_addr   (gst_req_addr),
        .gst_req_wr     (gst_req_wr),
        .gst_req_wdata  (gst_req_wdata),
        .gst_req_wmask  (gst_req_wmask),
        .gst_rsp_vld    (gst_rsp_vld),
        .gst_rsp_rdy    (gst_rsp_rdy),
        .gst_rsp_rdata  (gst_rsp_rdata),
        .gst_rsp_ok     (gst_rsp_ok),
        .ost_cnt        (ost_cnt),
        .err_stray      (err_stray)
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // ---------------- reference model ----------------
    function automatic int ref_decode(input logic [31:0] a);
        for (int g = 0; g < NG; g++) begin
            if (a[31:24] == sel_tab[g]) return g;
        end
        return NG;
    endfunction

    function automatic logic [31:0] ref_mask(input int g, input logic [31:0] a);
        return 32'(64'(a) % (64'd1 << aw_tab[g]));
    endfunction

    // Deterministic guest behaviour: response depends on what the guest saw
    function automatic logic [31:0] gfun(input int g, input logic [31:0] a, input logic wr,
                                         input logic [31:0] wd, input logic [3:0] wm);
        return a ^ {wd[15:0], wd[31:16]} ^ (32'(wm) << 8) ^ (32'(g) << 28) ^ 32'(wr);
    endfunction

    logic [32:0] exp_q [$];
    logic [32:0] gq [NG][$];
    int          n_req = 0;
    int          n_rsp = 0;

    always @(negedge clk) begin
        int          g;
        logic [31:0] ma;
        if (env_en && rst_n) begin
            if (host_req_vld && host_req_rdy) begin
                g = ref_decode(host_req_addr);
                if (g == NG) begin
                    exp_q.push_back({1'b0, 32'hDEAD_BEEF});
                end else begin
                    ma = ref_mask(g, host_req_addr);
                    exp_q.push_back({~ma[3], gfun(g, ma, host_req_wr, host_req_wdata, host_req_wmask)});
                end
                n_req++;
            end
            if (host_rsp_vld && host_rsp_rdy) begin
                if (exp_q.size() == 0) begin
                    chk("rsp_unexpected", 64'd1, 64'd0);
                end else begin
                    chk("rsp_data", host_rsp_rdata, exp_q[0][31:0]);
                    chk("rsp_ok", host_rsp_ok, exp_q[0][32]);
                    void'(exp_q.pop_front());
                    n_rsp++;
                end
            end
        end
    end

    // Guest environment: record accepted requests, note accepted responses
    always @(negedge clk) begin
        logic [31:0] a;
        if (env_en) begin
            for (int g = 0; g < NG; g++) begin
                env_acc[g] = gst_rsp_vld[g] && gst_rsp_rdy[g];
                if (env_acc[g]) void'(gq[g].pop_front());
                if (gst_req_vld[g] && gst_req_rdy[g]) begin
                    a = gst_req_addr[g*AW +: AW];
                    gq[g].push_back({~a[3], gfun(g, a, gst_req_wr[g], gst_req_wdata[g*DW +: DW],
                                                 gst_req_wmask[g*MW +: MW])});
                end
            end
        end
    end

    always @(posedge clk) begin
        if (env_en) begin
            #1;
            for (int g = 0; g < NG; g++) begin
                env_req_rdy[g] = ($urandom_range(3) != 0);
                // A response once offered is held until taken
                if (!env_rsp_vld[g] || env_acc[g]) begin
                    if (gq[g].size() > 0 && $urandom_range(1) == 1) begin
                        env_rsp_vld[g]           = 1'b1;
                        env_rsp_rdata[g*DW +: DW] = gq[g][0][31:0];
                        env_rsp_ok[g]            = gq[g][0][32];
                    end else begin
                        env_rsp_vld[g] = 1'b0;
                    end
                end
            end
            env_host_rsp_rdy = ($urandom_range(1) == 1);
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        int w;

        // Reset values, with a mapped request already presented
        host_req_vld  = 1'b1;
        host_req_addr = 32'h0000_0000;
        man_req_rdy   = 4'hF;
        #2;
        chk("rst_ost_cnt", ost_cnt, 0);
        chk("rst_rsp_vld", host_rsp_vld, 0);
        chk("rst_err_stray", err_stray, 0);
        chk("rst_req_rdy", host_req_rdy, 1);
        chk("rst_gst_req_vld", gst_req_vld, 0);
        host_req_vld = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();

        // Single read through guest 1, same-cycle forwarding, lowest index wins
        man_req_rdy    = 4'b0010;
        host_req_vld   = 1'b1;
        host_req_addr  = 32'h1000_0040;
        host_req_wr    = 1'b0;
        host_req_wmask = 4'hF;
        #1;
        chk("rd_gst_req_vld", gst_req_vld, 4'b0010);
        chk("rd_gst_addr", gst_req_addr[1*AW +: AW], 32'h0000_0040);
        chk("rd_gst_wmask", gst_req_wmask[1*MW +: MW], 4'hF);
        chk("rd_req_rdy", host_req_rdy, 1);
        tick();
        host_req_vld = 1'b0;
        #1;
        chk("rd_ost_cnt", ost_cnt, 1);
        chk("rd_rsp_wait", host_rsp_vld, 0);
        man_rsp_vld               = 4'b0010;
        man_rsp_rdata[1*DW +: DW] = 32'h0000_1234;
        man_rsp_ok                = 4'b0010;
        man_host_rsp_rdy          = 1'b1;
        #1;
        chk("rd_rsp_vld", host_rsp_vld, 1);
        chk("rd_rsp_rdata", host_rsp_rdata, 32'h0000_1234);
        chk("rd_rsp_ok", host_rsp_ok, 1);
        chk("rd_gst_rsp_rdy", gst_rsp_rdy, 4'b0010);
        tick();
        man_rsp_vld      = '0;
        man_host_rsp_rdy = 1'b0;
        #1;
        chk("rd_ost_after", ost_cnt, 0);
        chk("rd_no_stray", err_stray, 0);

        // Unmapped request is absorbed and answered with a decode error
        man_req_rdy   = '0;
        host_req_vld  = 1'b1;
        host_req_addr = 32'h5000_0000;
        host_req_wr   = 1'b1;
        #1;
        chk("de_gst_req_vld", gst_req_vld, 0);
        chk("de_req_rdy", host_req_rdy, 1);
        tick();
        host_req_vld     = 1'b0;
        man_host_rsp_rdy = 1'b1;
        #1;
        chk("de_rsp_vld", host_rsp_vld, 1);
        chk("de_rsp_rdata", host_rsp_rdata, 32'hDEAD_BEEF);
        chk("de_rsp_ok", host_rsp_ok, 0);
        chk("de_gst_rsp_rdy", gst_rsp_rdy, 0);
        tick();
        man_host_rsp_rdy = 1'b0;
        #1;
        chk("de_ost_after", ost_cnt, 0);

        // Out-of-order guest response stalls until its turn
        man_req_rdy   = 4'hF;
        host_req_wr   = 1'b0;
        host_req_vld  = 1'b1;
        host_req_addr = 32'h2000_0100;
        tick();
        host_req_addr = 32'h0000_0200;
        tick();
        host_req_vld = 1'b0;
        #1;
        chk("oo_ost_cnt", ost_cnt, 2);
        man_rsp_vld               = 4'b0001;
        man_rsp_rdata[0*DW +: DW] = 32'hAAAA_0000;
        man_rsp_ok                = 4'b0101;
        #1;
        chk("oo_hold_rdy", gst_rsp_rdy, 0);
        chk("oo_hold_vld", host_rsp_vld, 0);
        tick();
        chk("oo_err_stray", err_stray, 1);
        man_host_rsp_rdy          = 1'b1;
        man_rsp_vld               = 4'b0101;
        man_rsp_rdata[2*DW +: DW] = 32'hBBBB_2222;
        #1;
        chk("oo_first_rdata", host_rsp_rdata, 32'hBBBB_2222);
        chk("oo_first_rdy", gst_rsp_rdy, 4'b0100);
        tick();
        man_rsp_vld = 4'b0001;
        #1;
        chk("oo_second_vld", host_rsp_vld, 1);
        chk("oo_second_rdata", host_rsp_rdata, 32'hAAAA_0000);
        chk("oo_second_rdy", gst_rsp_rdy, 4'b0001);
        tick();
        man_rsp_vld      = '0;
        man_host_rsp_rdy = 1'b0;
        #1;
        chk("oo_ost_after", ost_cnt, 0);
        tick();
        chk("oo_stray_clear", err_stray, 0);

        // Fill to depth, no bypass when full, refill after one pop
        host_req_vld = 1'b1;
        for (int k = 0; k < 4; k++) begin
            host_req_addr = 32'h0000_0010 + 32'(k * 4);
            #1;
            chk("full_fill_rdy", host_req_rdy, 1);
            tick();
        end
        host_req_addr = 32'h0000_0020;
        #1;
        chk("full_req_rdy", host_req_rdy, 0);
        chk("full_ost_cnt", ost_cnt, 4);
        chk("full_gst_req_vld", gst_req_vld, 0);
        man_rsp_vld      = 4'b0001;
        man_host_rsp_rdy = 1'b1;
        #1;
        chk("full_pop_vld", host_rsp_vld, 1);
        chk("full_no_bypass", host_req_rdy, 0);
        tick();
        man_rsp_vld      = '0;
        man_host_rsp_rdy = 1'b0;
        #1;
        chk("full_after_pop_cnt", ost_cnt, 3);
        chk("full_after_pop_rdy", host_req_rdy, 1);
        tick();
        host_req_vld = 1'b0;
        #1;
        chk("full_refill_cnt", ost_cnt, 4);
        man_rsp_vld      = 4'b0001;
        man_host_rsp_rdy = 1'b1;
        repeat (4) tick();
        man_rsp_vld      = '0;
        man_host_rsp_rdy = 1'b0;
        #1;
        chk("full_drain_cnt", ost_cnt, 0);

        // Reset with requests outstanding; a late response is stray
        host_req_vld = 1'b1;
        for (int k = 0; k < 3; k++) begin
            host_req_addr = 32'h1000_0000 + 32'(k);
            tick();
        end
        host_req_vld = 1'b0;
        #1;
        chk("mr_ost_cnt", ost_cnt, 3);
        rst_n = 1'b0;
        #1;
        chk("mr_ost_zero", ost_cnt, 0);
        chk("mr_rsp_vld", host_rsp_vld, 0);
        tick();
        rst_n       = 1'b1;
        man_rsp_vld = 4'b0010;
        #1;
        chk("mr_late_rdy", gst_rsp_rdy, 0);
        tick();
        man_rsp_vld = '0;
        chk("mr_err_stray", err_stray, 1);
        tick();
        chk("mr_err_pulse", err_stray, 0);

        // Random mixed traffic against the reference queue
        env_en = 1'b1;
        tick();
        for (int n = 0; n < 40; n++) begin
            if ($urandom_range(3) == 0) begin
                host_req_vld = 1'b0;
                tick();
            end
            host_req_addr  = {tops[$urandom_range(5)], 24'($urandom)};
            host_req_wr    = ($urandom_range(1) == 1);
            host_req_wdata = $urandom;
            host_req_wmask = 4'($urandom);
            host_req_vld   = 1'b1;
            w = 0;
            @(negedge clk);
            while (!host_req_rdy && w < 300) begin
                w++;
                @(negedge clk);
            end
            chk("rand_req_accept", host_req_rdy, 1);
            tick();
        end
        host_req_vld = 1'b0;
        w = 0;
        while ((exp_q.size() != 0 || ost_cnt != 0) && w < 1000) begin
            w++;
            @(negedge clk);
        end
        chk("rand_drain_q", exp_q.size(), 0);
        chk("rand_drain_ost", ost_cnt, 0);
        chk("rand_req_count", n_req, 40);
        chk("rand_rsp_count", n_rsp, n_req);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
